// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int WIDTH_DEFAULT = 8;

   // Bit counter only has to reach WIDTH-1.
   function automatic int cnt_width(input int w);
      return $clog2(w);
   endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full add made of two half-add stages and an OR.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic s,
   output logic co
);

   logic h1_s;
   logic h1_c;
   logic h2_c;

   // First half-add on the operands, second half-add folds in the carry.
   always_comb begin
      h1_s = a ^ b;
      h1_c = a & b;
      s    = h1_s ^ c;
      h2_c = h1_s & c;
      co   = h1_c | h2_c;
   end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-add cell, LSB first, WIDTH cycles per add.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high, last result held
// RUN   | one operand bit added per cycle, LSB first
// DONE  | result presented with out_valid, held until out_ready
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_MSB  = CNT_W'(WIDTH - 2);

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic             carry;
   logic             c_msb_in;
   logic [CNT_W-1:0] bit_cnt;
   logic             cell_s;
   logic             cell_co;
   logic             last_bit;

   assign last_bit = (bit_cnt == CNT_LAST);

   fa_cell u_fa_cell (
      .a  (sh_a[0]),
      .b  (sh_b[0]),
      .c  (carry),
      .s  (cell_s),
      .co (cell_co)
   );

   // State register; out_valid is registered from the next-state decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nx;
         out_valid <= (state_nx == DONE);
      end
   end

   // Next-state and handshake decode.
   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = RUN;
         end
         RUN:  if (last_bit) state_nx = DONE;
         DONE: if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Operand shifters, carry, bit counter and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_a     <= '0;
         sh_b     <= '0;
         carry    <= 1'b0;
         c_msb_in <= 1'b0;
         bit_cnt  <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sh_a    <= a;
                  sh_b    <= b;
                  carry   <= cin;
                  bit_cnt <= '0;
               end
            end
            RUN: begin
               sum   <= {cell_s, sum[WIDTH-1:1]};
               carry <= cell_co;
               sh_a  <= sh_a >> 1;
               sh_b  <= sh_b >> 1;
               if (bit_cnt == CNT_MSB) c_msb_in <= cell_co;
               if (last_bit) begin
                  cout    <= cell_co;
                  ovf     <= cell_co ^ c_msb_in;
                  // Park the counter rather than letting it wrap.
                  bit_cnt <= '0;
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   // Present operands for one edge; returns on the negedge after the accepting edge.
   task automatic accept(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic ic);
      @(negedge clk);
      a = ia; b = ib; cin = ic; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Count negedges until out_valid, bounded.
   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic release_result;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0;
      #1;
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready_during: got %b expected 1", in_ready); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 8'h00 || cout !== 1'b0 || ovf !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b expected 1 0 00 0 0",
                  in_ready, out_valid, sum, cout, ovf);
      end
   endtask

   typedef struct {
      logic [7:0] va;
      logic [7:0] vb;
      logic       vc;
      logic [7:0] es;
      logic       ec;
      logic       eo;
   } vec_t;

   task automatic test_vectors;
      vec_t vecs[4];
      int   cyc;
      vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
      vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) begin
         accept(vecs[i].va, vecs[i].vb, vecs[i].vc);
         wait_valid(cyc);
         tests++;
         if (cyc !== WIDTH) begin fails++; $display("FAIL vec%0d latency: got %0d expected %0d", i, cyc, WIDTH); end
         tests++;
         if (sum !== vecs[i].es) begin fails++; $display("FAIL vec%0d sum: got %h expected %h", i, sum, vecs[i].es); end
         tests++;
         if (cout !== vecs[i].ec) begin fails++; $display("FAIL vec%0d cout: got %b expected %b", i, cout, vecs[i].ec); end
         tests++;
         if (ovf !== vecs[i].eo) begin fails++; $display("FAIL vec%0d ovf: got %b expected %b", i, ovf, vecs[i].eo); end
         release_result;
         tests++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL vec%0d return_idle: in_ready=%b out_valid=%b expected 1 0", i, in_ready, out_valid);
         end
      end
   endtask

   task automatic test_backpressure;
      int cyc;
      accept(8'h12, 8'h34, 1'b0);
      tests++;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready_run: got %b expected 0", in_ready); end
      wait_valid(cyc);
      tests++;
      if (cyc !== WIDTH) begin fails++; $display("FAIL bp_latency: got %0d expected %0d", cyc, WIDTH); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 8'h46 || cout !== 1'b0 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b sum=%h cout=%b ovf=%b expected 1 0 46 0 0",
                     i, out_valid, in_ready, sum, cout, ovf);
         end
      end
      release_result;
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 8'h46) begin
         fails++;
         $display("FAIL bp_release: in_ready=%b out_valid=%b sum=%h expected 1 0 46", in_ready, out_valid, sum);
      end
   endtask

   task automatic test_ignore_run;
      int cyc;
      @(negedge clk);
      a = 8'h03; b = 8'h04; cin = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      a = 8'h10; b = 8'h20;
      wait_valid(cyc);
      tests++;
      if (cyc !== WIDTH || sum !== 8'h07) begin
         fails++;
         $display("FAIL ignore_first: latency=%0d sum=%h expected %0d 07", cyc, sum, WIDTH);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL ignore_idle: in_ready=%b expected 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      wait_valid(cyc);
      tests++;
      if (cyc !== WIDTH || sum !== 8'h30 || cout !== 1'b0 || ovf !== 1'b0) begin
         fails++;
         $display("FAIL ignore_second: latency=%0d sum=%h cout=%b ovf=%b expected %0d 30 0 0", cyc, sum, cout, ovf, WIDTH);
      end
      release_result;
   endtask

   task automatic test_reset_mid_run;
      int cyc;
      accept(8'h80, 8'h80, 1'b0);
      wait_valid(cyc);
      release_result;
      accept(8'hFF, 8'h00, 1'b0);
      repeat (3) @(negedge clk);
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || sum !== 8'hE0 || cout !== 1'b1) begin
         fails++;
         $display("FAIL abort_pre: out_valid=%b in_ready=%b sum=%h cout=%b expected 0 0 e0 1", out_valid, in_ready, sum, cout);
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (sum !== 8'h00 || cout !== 1'b0 || ovf !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL abort_reset: sum=%h cout=%b ovf=%b out_valid=%b in_ready=%b expected 00 0 0 0 1",
                  sum, cout, ovf, out_valid, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      accept(8'h01, 8'h01, 1'b0);
      wait_valid(cyc);
      tests++;
      if (cyc !== WIDTH || sum !== 8'h02 || cout !== 1'b0 || ovf !== 1'b0) begin
         fails++;
         $display("FAIL abort_fresh: latency=%0d sum=%h cout=%b ovf=%b expected %0d 02 0 0", cyc, sum, cout, ovf, WIDTH);
      end
      release_result;
   endtask

   initial begin
      test_reset;
      test_vectors;
      test_backpressure;
      test_ignore_run;
      test_reset_mid_run;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
